alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined ALU for the datapath practice series.
- Successor to the 4-bit combinational operand preprocessor: it includes operand preprocessing (operand select, one's-complement, +1 carry-in) and the adder/logic unit.
- Adds generic width, a valid/ready handshake, flag generation, and an accumulator source with a pipeline interlock.
- Sits between the operand register file/sequencer and the writeback logic.

Parameters:
- W, 4, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  an operation is presented.
- in_ready  output  1  the block accepts the operation this cycle.
- in_op  input  3  operation code (see Behaviour).
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_acc  input  1  1 = use the accumulator instead of in_a as operand A.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- out_res  output  W  result.
- out_flags  output  4  {N, Z, C, V}.
- acc  output  W  accumulator (last result that left stage 1).

Behaviour:
- Reset (asynchronous, rst_n=0): s1_valid=0, out_valid=0, out_res=0, out_flags=0, acc=0. Returning to operation needs no clock.
- Reset mid-operation: all in-flight operations are discarded.
- Opcodes:
  - 000 PASS_A: A
  - 001 NEG_A: ~A+1
  - 010 ADD: A+B
  - 011 SUB: A+~B+1
  - 100 AND
  - 101 OR
  - 110 XOR
  - 111 INC_A: A+1
- Stage 0 (combinational, at acceptance): resolve A_src = in_acc ? acc : in_a. Produce the preprocessed operands:
  - AMod: A_src, except 0 for NEG_A.
  - BMod: B for ADD/logic ops, ~B for SUB, ~A_src for NEG_A, 0 for PASS_A/INC_A.
  - cin: 1 for NEG_A, SUB and INC_A.
- Stage 1 register: captures AMod, BMod, cin and op on acceptance (in_valid & in_ready).
- Stage 2 register: computes the result and flags from stage 1. Arithmetic ops use a (W+1)-bit sum AMod+BMod+cin.
- Flags:
  - C = sum[W] (carry/no-borrow).
  - V = signed overflow (carry into MSB XOR carry out).
  - N = res[W-1].
  - Z = (res==0).
  - Logic ops force C=0 and V=0.
- Accumulator: acc loads the stage-2 result in the same cycle stage 1 advances into stage 2.
- Handshake:
  - s2_go = !out_valid | out_ready.
  - s1_go = s1_valid & s2_go.
  - in_ready = (!s1_valid | s1_go) & !(in_acc & s1_valid).
- Accumulator interlock: an in_acc operation is held off while any operation is still in stage 1. The acc it reads therefore always includes the preceding operation.
  - The in_ready path from in_acc is combinational by design.
- Latency and throughput: 2 cycles from acceptance to out_valid. Throughput is 1 op/cycle for non-acc streams and 1 op/2 cycles for back-to-back acc chains.
- Backpressure: out_valid/out_res/out_flags hold stable while out_valid=1 and out_ready=0. Stage 1 holds. in_ready falls once stage 1 is full.
- Simultaneous events: acceptance and stage-1 advance in the same cycle are legal; no bubble is inserted. The output handshake and a new stage-2 load in the same cycle replace the result without a gap.
- Wrap-around: results are modulo 2^W unless the optional feature is enabled.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: ADD/SUB/NEG_A/INC_A results saturate on V=1.
  - Positive overflow gives 0 followed by W-1 ones.
  - Negative overflow gives 1 followed by W-1 zeros.
  - V is still reported; Z/N are computed on the saturated value.
  - Adds a fifth flag-independent output port out_sat (1 = saturation occurred), reset to 0.
- Undefined: modulo wrap, no out_sat port.

Test Plan:
- Reset: assert rst_n=0 mid-stream with two ops in flight → out_valid=0, acc=0 immediately, no clock needed. First op after release appears 2 cycles after acceptance.
- W=4 arithmetic: ADD 7+1 → res=1000, flags N=1,Z=0,C=0,V=1. SUB 3-3 → res=0000, Z=1, C=1. NEG_A 0001 → 1111, N=1. INC_A 1111 → 0000, Z=1, C=1.
- Logic: AND 1100&1010 → 1000, C=0, V=0. XOR equal operands → 0000, Z=1.
- Backpressure: stream 4 ADDs with out_ready=0 for 3 cycles →
  - out_res holds the first result; in_ready=0 once stage 1 is full.
  - All 4 results emerge in order with no loss or duplication after out_ready=1.
- Accumulator chain: ADD 2+3, then in_acc ADD b=4 offered the next cycle →
  - in_ready=0 for one cycle (interlock).
  - Second result = 9, acc=9.
- W=8 with ALU_SAT_EN: ADD 0x7F+0x01 → res=0x7F, V=1, out_sat=1. SUB 0x80-0x01 → 0x80, out_sat=1. Without the macro: 0x80 and 0x7F respectively.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Operation/result bundle for alu_pipe; the ALU drives through 'slave', the source/sink through 'master'.
// out_sat is present only when ALU_SAT_EN is defined.
interface alu_pipe_if #(parameter int W = 4);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_acc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic [3:0]   out_flags;
  logic [W-1:0] acc;
`ifdef ALU_SAT_EN
  logic         out_sat;

  modport master (output in_valid, in_op, in_a, in_b, in_acc, out_ready,
                  input  in_ready, out_valid, out_res, out_flags, acc, out_sat);
  modport slave  (input  in_valid, in_op, in_a, in_b, in_acc, out_ready,
                  output in_ready, out_valid, out_res, out_flags, acc, out_sat);
`else
  modport master (output in_valid, in_op, in_a, in_b, in_acc, out_ready,
                  input  in_ready, out_valid, out_res, out_flags, acc);
  modport slave  (input  in_valid, in_op, in_a, in_b, in_acc, out_ready,
                  output in_ready, out_valid, out_res, out_flags, acc);
`endif
endinterface

// File: rtl/alu_pipe.sv
// Two-stage W-bit ALU: operand preprocessing into stage 1, add/logic + flags into stage 2, with accumulator.
// Optional ALU_SAT_EN: saturate arithmetic results on signed overflow and report out_sat.
module alu_pipe #(
  parameter int W = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_NEG  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_INC  = 3'b111
  } op_e;

  typedef struct packed {
    op_e          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } s1_t;

  s1_t          s1_d, s1_q;
  logic         s1_valid_q, out_valid_q;
  logic [W-1:0] res_d, res_q, acc_q, a_src;
  logic [3:0]   flags_d, flags_q;
  logic         c_d, v_d, c_msb;
  logic [W:0]   sum;
  logic         s2_go, s1_go, in_ready, accept;
`ifdef ALU_SAT_EN
  logic         sat_d, sat_q;
`endif

  // Handshake; the in_acc term holds an acc op until its predecessor has left stage 1
  assign s2_go    = !out_valid_q || bus.out_ready;
  assign s1_go    = s1_valid_q && s2_go;
  assign in_ready = (!s1_valid_q || s1_go) && !(bus.in_acc && s1_valid_q);
  assign accept   = bus.in_valid && in_ready;

  assign a_src = bus.in_acc ? acc_q : bus.in_a;

  always_comb begin
    s1_d.op  = op_e'(bus.in_op);
    s1_d.a   = a_src;
    s1_d.b   = bus.in_b;
    s1_d.cin = 1'b0;
    case (op_e'(bus.in_op))
      OP_PASS: s1_d.b = '0;
      OP_NEG: begin
        s1_d.a   = '0;
        s1_d.b   = ~a_src;
        s1_d.cin = 1'b1;
      end
      OP_SUB: begin
        s1_d.b   = ~bus.in_b;
        s1_d.cin = 1'b1;
      end
      OP_INC: begin
        s1_d.b   = '0;
        s1_d.cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum   = {1'b0, s1_q.a} + {1'b0, s1_q.b} + {{W{1'b0}}, s1_q.cin};
  // Carry into the MSB recovered from the sum bit and the two operand MSBs
  assign c_msb = sum[W-1] ^ s1_q.a[W-1] ^ s1_q.b[W-1];

  always_comb begin
    res_d = sum[W-1:0];
    c_d   = sum[W];
    v_d   = c_msb ^ sum[W];
    case (s1_q.op)
      OP_AND: begin res_d = s1_q.a & s1_q.b; c_d = 1'b0; v_d = 1'b0; end
      OP_OR:  begin res_d = s1_q.a | s1_q.b; c_d = 1'b0; v_d = 1'b0; end
      OP_XOR: begin res_d = s1_q.a ^ s1_q.b; c_d = 1'b0; v_d = 1'b0; end
      default: ;
    endcase
`ifdef ALU_SAT_EN
    // A wrapped MSB of 1 means positive overflow, 0 means negative overflow
    sat_d = v_d;
    if (v_d) res_d = sum[W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    flags_d = {res_d[W-1], ~|res_d, c_d, v_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
      acc_q       <= '0;
    end else begin
      if (accept) s1_q <= s1_d;
      s1_valid_q <= accept || (s1_valid_q && !s1_go);
      if (s2_go) out_valid_q <= s1_valid_q;
      if (s1_go) begin
        res_q   <= res_d;
        flags_q <= flags_d;
        acc_q   <= res_d;
      end
    end
  end

`ifdef ALU_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sat_q <= 1'b0;
    else if (s1_go) sat_q <= sat_d;
  end
  assign bus.out_sat = sat_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = res_q;
  assign bus.out_flags = flags_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: W=4 vector table, backpressure, acc interlock, async reset, W=8 overflow cases.
module tb_alu_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_pipe_if #(.W(4)) b4 ();
  alu_pipe_if #(.W(8)) b8 ();
  alu_pipe #(.W(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  alu_pipe #(.W(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic [3:0] flags;  // {N,Z,C,V}
  } vec_t;

  vec_t vecs [11];
  int   checks = 0, failures = 0;
  int   k, got;
  logic ir;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic d4(input logic v, input logic [2:0] op, input logic [3:0] a,
                    input logic [3:0] b, input logic acc);
    b4.in_valid = v;
    b4.in_op    = op;
    b4.in_a     = a;
    b4.in_b     = b;
    b4.in_acc   = acc;
  endtask

  initial begin
    vecs[0]  = '{3'b010, 4'h7, 4'h1, 4'h8, 4'b1001};  // ADD 7+1 overflow
    vecs[1]  = '{3'b011, 4'h3, 4'h3, 4'h0, 4'b0110};  // SUB 3-3
    vecs[2]  = '{3'b001, 4'h1, 4'h0, 4'hF, 4'b1000};  // NEG_A 1
    vecs[3]  = '{3'b111, 4'hF, 4'h0, 4'h0, 4'b0110};  // INC_A F
    vecs[4]  = '{3'b100, 4'hC, 4'hA, 4'h8, 4'b1000};  // AND
    vecs[5]  = '{3'b110, 4'h5, 4'h5, 4'h0, 4'b0100};  // XOR equal
    vecs[6]  = '{3'b000, 4'hA, 4'h3, 4'hA, 4'b1000};  // PASS_A
    vecs[7]  = '{3'b101, 4'h3, 4'h4, 4'h7, 4'b0000};  // OR
    vecs[8]  = '{3'b010, 4'h8, 4'h8, 4'h0, 4'b0111};  // ADD -8+-8
    vecs[9]  = '{3'b011, 4'h2, 4'h5, 4'hD, 4'b1000};  // SUB 2-5
    vecs[10] = '{3'b001, 4'h8, 4'h0, 4'h8, 4'b1001};  // NEG_A -8
`ifdef ALU_SAT_EN
    vecs[0].res  = 4'h7; vecs[0].flags  = 4'b0001;
    vecs[8].res  = 4'h8; vecs[8].flags  = 4'b1011;
    vecs[10].res = 4'h7; vecs[10].flags = 4'b0001;
`endif

    d4(1'b0, 3'b000, 4'h0, 4'h0, 1'b0);
    b4.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.in_op = 3'b000; b8.in_a = '0; b8.in_b = '0; b8.in_acc = 1'b0;
    b8.out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    chk("rst_out_valid", b4.out_valid, 0);
    chk("rst_out_res", b4.out_res, 0);
    chk("rst_out_flags", b4.out_flags, 0);
    chk("rst_acc", b4.acc, 0);
    chk("rst_in_ready", b4.in_ready, 1);
`ifdef ALU_SAT_EN
    chk("rst_out_sat", b4.out_sat, 0);
`endif
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      d4(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      step();
      d4(1'b0, 3'b000, 4'h0, 4'h0, 1'b0);
      chk($sformatf("vec%0d_lat1", i), b4.out_valid, 0);
      step();
      chk($sformatf("vec%0d_valid", i), b4.out_valid, 1);
      chk($sformatf("vec%0d_res", i), b4.out_res, vecs[i].res);
      chk($sformatf("vec%0d_flags", i), b4.out_flags, vecs[i].flags);
    end
    step();

    // Backpressure: four ADDs (k+1)+1 with the sink stalled while the first result sits in stage 2
    k = 0; got = 0;
    for (int c = 0; c < 20; c++) begin
      b4.out_ready = (c >= 5);
      if (k < 4) d4(1'b1, 3'b010, 4'(k + 1), 4'h1, 1'b0);
      else       d4(1'b0, 3'b000, 4'h0, 4'h0, 1'b0);
      #1;
      ir = b4.in_ready;
      if (c >= 2 && c <= 4) begin
        chk("bp_hold_valid", b4.out_valid, 1);
        chk("bp_hold_res", b4.out_res, 2);
        chk("bp_in_ready", ir, 0);
      end
      if (b4.out_valid && b4.out_ready) begin
        if (got < 4) chk("bp_order", b4.out_res, got + 2);
        else         chk("bp_extra", b4.out_valid, 0);
        got++;
      end
      if (b4.in_valid && ir) k++;
      step();
    end
    chk("bp_count", got, 4);

    // Accumulator chain: ADD 2+3, then acc+4 offered the next cycle
    d4(1'b1, 3'b010, 4'h2, 4'h3, 1'b0);
    step();
    d4(1'b1, 3'b010, 4'hF, 4'h4, 1'b1);
    #1;
    chk("acc_interlock", b4.in_ready, 0);
    step();
    chk("acc_ready_after", b4.in_ready, 1);
    chk("acc_first", b4.acc, 5);
    chk("acc_first_res", b4.out_res, 5);
    step();
    d4(1'b0, 3'b000, 4'h0, 4'h0, 1'b0);
    step();
    chk("acc_second_valid", b4.out_valid, 1);
`ifdef ALU_SAT_EN
    chk("acc_second_res", b4.out_res, 7);
    chk("acc_second_acc", b4.acc, 7);
`else
    chk("acc_second_res", b4.out_res, 9);
    chk("acc_second_acc", b4.acc, 9);
`endif

    // Asynchronous reset with two ops in flight
    d4(1'b1, 3'b010, 4'h1, 4'h1, 1'b0);
    step();
    d4(1'b1, 3'b010, 4'h2, 4'h2, 1'b0);
    step();
    d4(1'b0, 3'b000, 4'h0, 4'h0, 1'b0);
    chk("pre_rst_valid", b4.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", b4.out_valid, 0);
    chk("mid_rst_acc", b4.acc, 0);
    chk("mid_rst_res", b4.out_res, 0);
    chk("mid_rst_flags", b4.out_flags, 0);
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_empty", b4.out_valid, 0);
    d4(1'b1, 3'b010, 4'h3, 4'h4, 1'b0);
    step();
    d4(1'b0, 3'b000, 4'h0, 4'h0, 1'b0);
    chk("post_rst_lat1", b4.out_valid, 0);
    step();
    chk("post_rst_valid", b4.out_valid, 1);
    chk("post_rst_res", b4.out_res, 7);
    chk("post_rst_flags", b4.out_flags, 0);

    // W=8 signed overflow: ADD 7F+01 then SUB 80-01
    b8.in_valid = 1'b1; b8.in_op = 3'b010; b8.in_a = 8'h7F; b8.in_b = 8'h01;
    step();
    b8.in_op = 3'b011; b8.in_a = 8'h80; b8.in_b = 8'h01;
    step();
    b8.in_valid = 1'b0;
    chk("w8_add_valid", b8.out_valid, 1);
    chk("w8_add_v", b8.out_flags[0], 1);
`ifdef ALU_SAT_EN
    chk("w8_add_res", b8.out_res, 8'h7F);
    chk("w8_add_sat", b8.out_sat, 1);
`else
    chk("w8_add_res", b8.out_res, 8'h80);
`endif
    step();
    chk("w8_sub_valid", b8.out_valid, 1);
    chk("w8_sub_v", b8.out_flags[0], 1);
`ifdef ALU_SAT_EN
    chk("w8_sub_res", b8.out_res, 8'h80);
    chk("w8_sub_sat", b8.out_sat, 1);
`else
    chk("w8_sub_res", b8.out_res, 8'h7F);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
